// File: rtl/move_scheduler_if.sv
// ----------------------------------------------------------------------------
// move_scheduler_if
//   Groups the request/arbitration and game-FSM bus signals of move_scheduler.
//
//   Handshake: req_mouse / req_key are level requests that the source holds
//   (with its cell index stable) until it sees either its own ack_* pulse or a
//   reject pulse. Exactly one of ack_mouse, ack_key or reject pulses for one
//   cycle per grant. A source whose request is not granted gets no pulse and
//   keeps requesting.
//
//   Signals
//     game_active  in   1  game in progress
//     occupied     in   9  occupied-cell map from the game FSM
//     req_mouse    in   1  mouse request (level)
//     mouse_cell   in   4  mouse cell index
//     req_key      in   1  keypad request (level)
//     key_cell     in   4  keypad cell index
//     cuadro       out  9  one-hot move to the game FSM
//     ack_mouse    out  1  mouse request accepted (pulse)
//     ack_key      out  1  keypad request accepted (pulse)
//     reject       out  1  granted request invalid (pulse)
//     busy         out  1  move being issued (HOLD or GAP)
//     timeout      out  1  turn timer expired (pulse)
//     last_cell    out  4  index of the last issued move
//   Modports: master = requesters/game side, slave = scheduler.
// ----------------------------------------------------------------------------
interface move_scheduler_if;
    logic       game_active;
    logic [8:0] occupied;
    logic       req_mouse;
    logic [3:0] mouse_cell;
    logic       req_key;
    logic [3:0] key_cell;
    logic [8:0] cuadro;
    logic       ack_mouse;
    logic       ack_key;
    logic       reject;
    logic       busy;
    logic       timeout;
    logic [3:0] last_cell;

    modport master (
        output game_active, occupied, req_mouse, mouse_cell, req_key, key_cell,
        input  cuadro, ack_mouse, ack_key, reject, busy, timeout, last_cell
    );

    modport slave (
        input  game_active, occupied, req_mouse, mouse_cell, req_key, key_cell,
        output cuadro, ack_mouse, ack_key, reject, busy, timeout, last_cell
    );
endinterface

// File: rtl/move_scheduler.sv
// ----------------------------------------------------------------------------
// move_scheduler
//   Arbitrates mouse and keypad cell selections round-robin, rejects
//   out-of-range or occupied cells, and drives the game FSM's one-hot cuadro
//   bus as a HOLD_CYCLES pulse followed by a GAP_CYCLES quiet gap. A per-turn
//   timer pulses timeout after TIMEOUT_CYCLES idle cycles of an active game.
//
//   Ports
//     clk_100MHz  in   1  system clock
//     reset       in   1  synchronous, active-high reset
//     bus         slave modport of move_scheduler_if (requests, cuadro, pulses)
//     state_o     out  2  current FSM state (0 IDLE, 1 HOLD, 2 GAP)
//
//   Optional feature: define AUTO_MOVE_EN to have a timeout issue the
//   lowest-index free cell as a move (no ack, RR pointer untouched).
// ----------------------------------------------------------------------------
module move_scheduler #(
    parameter int HOLD_CYCLES    = 4,
    parameter int GAP_CYCLES     = 2,
    parameter int TIMEOUT_CYCLES = 1000000000
) (
    input  logic             clk_100MHz,
    input  logic             reset,
    move_scheduler_if.slave  bus,
    output logic [1:0]       state_o
);
    localparam int HOLD_W  = $clog2(HOLD_CYCLES) + 1;
    localparam int GAP_W   = $clog2(GAP_CYCLES) + 1;
    localparam int TIMER_W = $clog2(TIMEOUT_CYCLES);

    localparam logic [HOLD_W-1:0]  HOLD_LAST  = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [GAP_W-1:0]   GAP_LAST   = GAP_W'(GAP_CYCLES - 1);
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HOLD = 2'd1,
        S_GAP  = 2'd2
    } state_t;

    state_t              state_q;
    logic [HOLD_W-1:0]   hold_cnt_q;
    logic [GAP_W-1:0]    gap_cnt_q;
    logic [TIMER_W-1:0]  timer_q;
    logic                rr_key_q;      // 1 = keypad has priority on a tie
    logic [8:0]          cuadro_q;
    logic                ack_mouse_q;
    logic                ack_key_q;
    logic                reject_q;
    logic                busy_q;
    logic                timeout_q;
    logic [3:0]          last_cell_q;

    // Arbitration and validity of the current grant candidate.
    logic        grant_any;
    logic        pick_key;
    logic [3:0]  grant_cell;
    logic [15:0] occ_ext;       // widened so any 4-bit index selects in range
    logic        grant_valid;

    always_comb begin
        grant_any   = (state_q == S_IDLE) && bus.game_active &&
                      (bus.req_mouse || bus.req_key);
        pick_key    = bus.req_key && (!bus.req_mouse || rr_key_q);
        grant_cell  = pick_key ? bus.key_cell : bus.mouse_cell;
        occ_ext     = {7'b0, bus.occupied};
        grant_valid = grant_any && (grant_cell <= 4'd8) && !occ_ext[grant_cell];
    end

`ifdef AUTO_MOVE_EN
    logic       free_any;
    logic [3:0] free_idx;

    // Scan downwards so the last hit is the lowest-index free cell.
    always_comb begin
        free_any = 1'b0;
        free_idx = 4'd0;
        for (int i = 8; i >= 0; i--) begin
            if (!bus.occupied[i]) begin
                free_any = 1'b1;
                free_idx = 4'(i);
            end
        end
    end
`endif

    always_ff @(posedge clk_100MHz) begin
        if (reset) begin
            state_q     <= S_IDLE;
            hold_cnt_q  <= '0;
            gap_cnt_q   <= '0;
            timer_q     <= '0;
            rr_key_q    <= 1'b0;
            cuadro_q    <= '0;
            ack_mouse_q <= 1'b0;
            ack_key_q   <= 1'b0;
            reject_q    <= 1'b0;
            busy_q      <= 1'b0;
            timeout_q   <= 1'b0;
            last_cell_q <= '0;
        end else begin
            ack_mouse_q <= 1'b0;
            ack_key_q   <= 1'b0;
            reject_q    <= 1'b0;
            timeout_q   <= 1'b0;

            case (state_q)
                S_IDLE: begin
                    if (!bus.game_active) begin
                        timer_q <= '0;
                    end else begin
                        if (grant_any) begin
                            rr_key_q <= !pick_key;
                        end
                        if (grant_valid) begin
                            // A valid grant beats a timer expiry in the same cycle.
                            ack_mouse_q <= !pick_key;
                            ack_key_q   <= pick_key;
                            cuadro_q    <= 9'd1 << grant_cell;
                            last_cell_q <= grant_cell;
                            busy_q      <= 1'b1;
                            hold_cnt_q  <= '0;
                            timer_q     <= '0;
                            state_q     <= S_HOLD;
                        end else begin
                            // Rejected grants leave the turn timer running.
                            reject_q <= grant_any;
                            if (timer_q == TIMER_LAST) begin
                                timer_q   <= '0;
                                timeout_q <= 1'b1;
`ifdef AUTO_MOVE_EN
                                if (free_any) begin
                                    cuadro_q    <= 9'd1 << free_idx;
                                    last_cell_q <= free_idx;
                                    busy_q      <= 1'b1;
                                    hold_cnt_q  <= '0;
                                    state_q     <= S_HOLD;
                                end
`endif
                            end else begin
                                timer_q <= timer_q + TIMER_W'(1);
                            end
                        end
                    end
                end

                S_HOLD: begin
                    if (hold_cnt_q == HOLD_LAST) begin
                        cuadro_q  <= '0;
                        gap_cnt_q <= '0;
                        state_q   <= S_GAP;
                    end else begin
                        hold_cnt_q <= hold_cnt_q + HOLD_W'(1);
                    end
                end

                S_GAP: begin
                    if (gap_cnt_q == GAP_LAST) begin
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end else begin
                        gap_cnt_q <= gap_cnt_q + GAP_W'(1);
                    end
                end

                default: begin
                    cuadro_q <= '0;
                    busy_q   <= 1'b0;
                    state_q  <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.cuadro    = cuadro_q;
    assign bus.ack_mouse = ack_mouse_q;
    assign bus.ack_key   = ack_key_q;
    assign bus.reject    = reject_q;
    assign bus.busy      = busy_q;
    assign bus.timeout   = timeout_q;
    assign bus.last_cell = last_cell_q;
    assign state_o       = state_q;
endmodule

// File: tb/tb_move_scheduler.sv
// ----------------------------------------------------------------------------
// tb_move_scheduler
//   Directed bench for move_scheduler with HOLD=4, GAP=2, TIMEOUT=20.
//   Inputs change 1 time unit after each rising edge; outputs are sampled at
//   the same point, i.e. they show the result of the edge just taken.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_move_scheduler;
    logic       clk;
    logic       reset;
    logic [1:0] state_o;
    int         checks;
    int         errors;

    move_scheduler_if bus_if();

    move_scheduler #(
        .HOLD_CYCLES   (4),
        .GAP_CYCLES    (2),
        .TIMEOUT_CYCLES(20)
    ) dut (
        .clk_100MHz(clk),
        .reset     (reset),
        .bus       (bus_if.slave),
        .state_o   (state_o)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus_if.req_mouse  = 1'b0;
        bus_if.mouse_cell = 4'd0;
        bus_if.req_key    = 1'b0;
        bus_if.key_cell   = 4'd0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle_inputs();
        tick();
        tick();
        reset = 1'b0;
    endtask

    // Tests
    task automatic test_reset();
        bus_if.game_active = 1'b1;
        bus_if.occupied    = 9'h000;
        do_reset();
        checks++; if (bus_if.cuadro !== 9'h000) begin errors++; $display("FAIL reset_cuadro: got %h expected 000", bus_if.cuadro); end
        checks++; if (bus_if.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", bus_if.busy); end
        checks++; if (bus_if.last_cell !== 4'd0) begin errors++; $display("FAIL reset_last_cell: got %0d expected 0", bus_if.last_cell); end
        checks++; if ({bus_if.ack_mouse, bus_if.ack_key, bus_if.reject, bus_if.timeout} !== 4'b0000) begin errors++; $display("FAIL reset_pulses: got %b expected 0000", {bus_if.ack_mouse, bus_if.ack_key, bus_if.reject, bus_if.timeout}); end
        checks++; if (state_o !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", state_o); end
    endtask

    task automatic test_single_move();
        do_reset();
        bus_if.req_mouse  = 1'b1;
        bus_if.mouse_cell = 4'd4;
        tick();
        bus_if.req_mouse = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checks++; if (bus_if.cuadro !== 9'h010 || bus_if.busy !== 1'b1) begin errors++; $display("FAIL single_hold[%0d]: got cuadro %h busy %b expected 010 1", i, bus_if.cuadro, bus_if.busy); end
            checks++; if (bus_if.ack_mouse !== (i == 0)) begin errors++; $display("FAIL single_ack[%0d]: got %b expected %b", i, bus_if.ack_mouse, (i == 0)); end
            tick();
        end
        for (int i = 0; i < 2; i++) begin
            checks++; if (bus_if.cuadro !== 9'h000 || bus_if.busy !== 1'b1) begin errors++; $display("FAIL single_gap[%0d]: got cuadro %h busy %b expected 000 1", i, bus_if.cuadro, bus_if.busy); end
            tick();
        end
        checks++; if (bus_if.busy !== 1'b0 || state_o !== 2'd0) begin errors++; $display("FAIL single_end: got busy %b state %0d expected 0 0", bus_if.busy, state_o); end
        checks++; if (bus_if.last_cell !== 4'd4) begin errors++; $display("FAIL single_last_cell: got %0d expected 4", bus_if.last_cell); end
    endtask

    task automatic test_round_robin();
        do_reset();
        bus_if.req_mouse  = 1'b1;
        bus_if.mouse_cell = 4'd0;
        bus_if.req_key    = 1'b1;
        bus_if.key_cell   = 4'd8;
        tick();
        checks++; if (bus_if.ack_mouse !== 1'b1 || bus_if.ack_key !== 1'b0 || bus_if.cuadro !== 9'h001) begin errors++; $display("FAIL rr_first: got ackm %b ackk %b cuadro %h expected 1 0 001", bus_if.ack_mouse, bus_if.ack_key, bus_if.cuadro); end
        bus_if.req_mouse = 1'b0;
        // Key keeps requesting through HOLD/GAP and must be ignored there.
        for (int i = 0; i < 6; i++) begin
            tick();
            checks++; if (bus_if.ack_key !== 1'b0 || bus_if.reject !== 1'b0) begin errors++; $display("FAIL rr_ignored[%0d]: got ackk %b reject %b expected 0 0", i, bus_if.ack_key, bus_if.reject); end
        end
        tick();
        checks++; if (bus_if.ack_key !== 1'b1 || bus_if.cuadro !== 9'h100 || bus_if.last_cell !== 4'd8) begin errors++; $display("FAIL rr_second: got ackk %b cuadro %h last %0d expected 1 100 8", bus_if.ack_key, bus_if.cuadro, bus_if.last_cell); end
        bus_if.req_key = 1'b0;
    endtask

    task automatic test_reject();
        do_reset();
        bus_if.req_mouse  = 1'b1;
        bus_if.mouse_cell = 4'd3;
        tick();
        bus_if.req_mouse = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        checks++; if (bus_if.busy !== 1'b0 || bus_if.last_cell !== 4'd3) begin errors++; $display("FAIL rej_setup: got busy %b last %0d expected 0 3", bus_if.busy, bus_if.last_cell); end
        // Out-of-range cell while the pointer favours the keypad.
        bus_if.req_key  = 1'b1;
        bus_if.key_cell = 4'd9;
        tick();
        checks++; if (bus_if.reject !== 1'b1 || bus_if.ack_key !== 1'b0 || bus_if.cuadro !== 9'h000 || bus_if.busy !== 1'b0) begin errors++; $display("FAIL rej_range: got rej %b ackk %b cuadro %h busy %b expected 1 0 000 0", bus_if.reject, bus_if.ack_key, bus_if.cuadro, bus_if.busy); end
        checks++; if (bus_if.last_cell !== 4'd3) begin errors++; $display("FAIL rej_last_cell: got %0d expected 3", bus_if.last_cell); end
        // Occupied cell.
        bus_if.occupied = 9'h004;
        bus_if.key_cell = 4'd2;
        tick();
        checks++; if (bus_if.reject !== 1'b1 || bus_if.cuadro !== 9'h000) begin errors++; $display("FAIL rej_occupied: got rej %b cuadro %h expected 1 000", bus_if.reject, bus_if.cuadro); end
        bus_if.req_key = 1'b0;
        tick();
        checks++; if (bus_if.reject !== 1'b0) begin errors++; $display("FAIL rej_one_cycle: got %b expected 0", bus_if.reject); end
        // Pointer flipped back to mouse after the keypad grants.
        bus_if.req_mouse  = 1'b1;
        bus_if.mouse_cell = 4'd5;
        bus_if.req_key    = 1'b1;
        bus_if.key_cell   = 4'd6;
        tick();
        checks++; if (bus_if.ack_mouse !== 1'b1 || bus_if.ack_key !== 1'b0 || bus_if.cuadro !== 9'h020) begin errors++; $display("FAIL rej_next_mouse: got ackm %b ackk %b cuadro %h expected 1 0 020", bus_if.ack_mouse, bus_if.ack_key, bus_if.cuadro); end
        idle_inputs();
        bus_if.occupied = 9'h000;
    endtask

    task automatic test_timeout();
        do_reset();
        bus_if.occupied = 9'h003;
        for (int i = 1; i < 20; i++) begin
            tick();
            checks++; if (bus_if.timeout !== 1'b0) begin errors++; $display("FAIL to_early[%0d]: got %b expected 0", i, bus_if.timeout); end
        end
        tick();
        checks++; if (bus_if.timeout !== 1'b1) begin errors++; $display("FAIL to_pulse: got %b expected 1", bus_if.timeout); end
`ifdef AUTO_MOVE_EN
        checks++; if (bus_if.cuadro !== 9'h004 || bus_if.last_cell !== 4'd2 || bus_if.busy !== 1'b1 || bus_if.ack_mouse !== 1'b0) begin errors++; $display("FAIL to_auto: got cuadro %h last %0d busy %b ackm %b expected 004 2 1 0", bus_if.cuadro, bus_if.last_cell, bus_if.busy, bus_if.ack_mouse); end
`else
        checks++; if (bus_if.cuadro !== 9'h000 || bus_if.busy !== 1'b0 || state_o !== 2'd0) begin errors++; $display("FAIL to_no_move: got cuadro %h busy %b state %0d expected 000 0 0", bus_if.cuadro, bus_if.busy, state_o); end
`endif
        tick();
        checks++; if (bus_if.timeout !== 1'b0) begin errors++; $display("FAIL to_one_cycle: got %b expected 0", bus_if.timeout); end
        // Full board: only the pulse, never a move.
        do_reset();
        bus_if.occupied = 9'h1FF;
        for (int i = 0; i < 20; i++) tick();
        checks++; if (bus_if.timeout !== 1'b1 || bus_if.busy !== 1'b0 || bus_if.cuadro !== 9'h000) begin errors++; $display("FAIL to_full: got to %b busy %b cuadro %h expected 1 0 000", bus_if.timeout, bus_if.busy, bus_if.cuadro); end
        bus_if.occupied = 9'h000;
    endtask

    task automatic test_game_inactive();
        do_reset();
        bus_if.game_active = 1'b0;
        bus_if.req_mouse   = 1'b1;
        bus_if.mouse_cell  = 4'd1;
        for (int i = 0; i < 25; i++) begin
            tick();
            checks++; if (bus_if.ack_mouse !== 1'b0 || bus_if.reject !== 1'b0 || bus_if.timeout !== 1'b0) begin errors++; $display("FAIL inactive[%0d]: got ackm %b rej %b to %b expected 0 0 0", i, bus_if.ack_mouse, bus_if.reject, bus_if.timeout); end
        end
        bus_if.req_mouse   = 1'b0;
        bus_if.game_active = 1'b1;
        bus_if.occupied    = 9'h1FF;
        for (int i = 0; i < 19; i++) tick();
        checks++; if (bus_if.timeout !== 1'b0) begin errors++; $display("FAIL inactive_cleared: got %b expected 0", bus_if.timeout); end
        tick();
        checks++; if (bus_if.timeout !== 1'b1) begin errors++; $display("FAIL inactive_then_to: got %b expected 1", bus_if.timeout); end
        bus_if.occupied = 9'h000;
    endtask

    task automatic test_expiry_grant();
        do_reset();
        for (int i = 0; i < 19; i++) tick();
        bus_if.req_mouse  = 1'b1;
        bus_if.mouse_cell = 4'd7;
        tick();
        checks++; if (bus_if.ack_mouse !== 1'b1 || bus_if.timeout !== 1'b0 || bus_if.cuadro !== 9'h080) begin errors++; $display("FAIL expiry_grant: got ackm %b to %b cuadro %h expected 1 0 080", bus_if.ack_mouse, bus_if.timeout, bus_if.cuadro); end
        bus_if.req_mouse = 1'b0;
        // Timer restarted from the grant: no pulse during the move.
        for (int i = 0; i < 7; i++) tick();
        checks++; if (bus_if.timeout !== 1'b0 || bus_if.busy !== 1'b0) begin errors++; $display("FAIL expiry_cleared: got to %b busy %b expected 0 0", bus_if.timeout, bus_if.busy); end
    endtask

    task automatic test_reset_in_hold();
        do_reset();
        bus_if.req_mouse  = 1'b1;
        bus_if.mouse_cell = 4'd4;
        tick();
        bus_if.req_mouse = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        checks++; if (bus_if.cuadro !== 9'h000 || bus_if.busy !== 1'b0 || state_o !== 2'd0 || bus_if.ack_mouse !== 1'b0) begin errors++; $display("FAIL rst_hold: got cuadro %h busy %b state %0d ackm %b expected 000 0 0 0", bus_if.cuadro, bus_if.busy, state_o, bus_if.ack_mouse); end
        reset = 1'b0;
        bus_if.req_key  = 1'b1;
        bus_if.key_cell = 4'd6;
        tick();
        checks++; if (bus_if.ack_key !== 1'b1 || bus_if.cuadro !== 9'h040 || bus_if.last_cell !== 4'd6) begin errors++; $display("FAIL rst_regrant: got ackk %b cuadro %h last %0d expected 1 040 6", bus_if.ack_key, bus_if.cuadro, bus_if.last_cell); end
        bus_if.req_key = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        bus_if.game_active = 1'b1;
        bus_if.occupied    = 9'h000;
        idle_inputs();
        #1;
        test_reset();
        test_single_move();
        test_round_robin();
        test_reject();
        test_timeout();
        test_game_inactive();
        test_expiry_grant();
        test_reset_in_hold();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
